rob_queue: RTL and testbench



---
 rtl/rob_queue.sv | 148 ++++++++++++++
 tb/tb_rob_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_queue.sv
// rtl/rob_queue.sv - in-order-retire reorder buffer with dual commit and mispredict flush
// Optional macro ROB_BYPASS_EN: operand lookup also matches same-cycle writeback buses.
module rob_queue #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int TAG_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush_in,
    output logic             full,
    input  logic             alloc_valid,
    input  logic [1:0]       alloc_kind,
    input  logic [4:0]       alloc_rd,
    input  logic [XLEN-1:0]  alloc_pred_pc,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic [TAG_W-1:0] qj,
    input  logic [TAG_W-1:0] qk,
    output logic             vj_ok,
    output logic             vk_ok,
    output logic [XLEN-1:0]  vj,
    output logic [XLEN-1:0]  vk,
    input  logic [TAG_W-1:0] lsb_dest,
    input  logic [XLEN-1:0]  lsb_value,
    input  logic [TAG_W-1:0] rss_dest,
    input  logic [XLEN-1:0]  rss_value,
    input  logic [XLEN-1:0]  rss_next_pc,
    output logic [TAG_W-1:0] c0_tag,
    output logic [TAG_W-1:0] c1_tag,
    output logic [4:0]       c0_rd,
    output logic [4:0]       c1_rd,
    output logic [XLEN-1:0]  c0_value,
    output logic [XLEN-1:0]  c1_value,
    output logic             store_commit,
    output logic             flush_out,
    output logic [XLEN-1:0]  flush_pc
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [1:0] K_NORM = 2'd0, K_BR = 2'd1, K_ST = 2'd2;

    logic [IDX_W-1:0] head, tail, head1, lsb_idx, rss_idx;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] done, done_n;
    logic [1:0]       kind    [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [XLEN-1:0]  value_q [DEPTH];
    logic [XLEN-1:0]  pred_pc [DEPTH];
    logic [XLEN-1:0]  real_pc [DEPTH];
    logic alloc_fire, fire0, fire1, mis0, mis1, mispredict, norm0, norm1;

    assign full       = (count == CNT_W'(DEPTH));
    assign alloc_tag  = TAG_W'(tail) + TAG_W'(1);
    assign alloc_fire = alloc_valid && !full;
    assign head1      = head + IDX_W'(1);
    assign lsb_idx    = IDX_W'(lsb_dest - TAG_W'(1));
    assign rss_idx    = IDX_W'(rss_dest - TAG_W'(1));

    // Slot 1 only pairs with a plain head so a branch or store never retires beside a younger entry.
    assign fire0 = done[head] && (count != '0);
    assign fire1 = fire0 && (kind[head] != K_BR) && (kind[head] != K_ST) &&
                   done[head1] && (kind[head1] != K_ST) && (count >= CNT_W'(2));
    assign norm0 = fire0 && (kind[head] == K_NORM);
    assign norm1 = fire1 && (kind[head1] == K_NORM);
    assign mis0  = fire0 && (kind[head] == K_BR) && (pred_pc[head] != real_pc[head]);
    assign mis1  = fire1 && (kind[head1] == K_BR) && (pred_pc[head1] != real_pc[head1]);
    assign mispredict = mis0 || mis1;

    always_comb begin
        done_n = done;
        if (alloc_fire)       done_n[tail]    = 1'b0;
        if (fire0)            done_n[head]    = 1'b0;
        if (fire1)            done_n[head1]   = 1'b0;
        if (lsb_dest != '0)   done_n[lsb_idx] = 1'b1;
        if (rss_dest != '0)   done_n[rss_idx] = 1'b1;
    end

    function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] q);
        logic [IDX_W-1:0] idx;
        logic [XLEN:0]    r;
        idx = IDX_W'(q - TAG_W'(1));
        r   = '0;
        if (q != '0) begin
            if (done[idx]) r = {1'b1, value_q[idx]};
`ifdef ROB_BYPASS_EN
            if (lsb_dest == q) r = {1'b1, lsb_value};
            if (rss_dest == q) r = {1'b1, rss_value};
`endif
        end
        return r;
    endfunction

    always_comb begin
        {vj_ok, vj} = lookup(qj);
        {vk_ok, vk} = lookup(qk);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0; tail <= '0; count <= '0; done <= '0;
            c0_tag <= '0; c0_rd <= '0; c0_value <= '0;
            c1_tag <= '0; c1_rd <= '0; c1_value <= '0;
            store_commit <= 1'b0; flush_out <= 1'b0; flush_pc <= '0;
        end else if (rdy) begin
            if (flush_in) begin
                head <= '0; tail <= '0; count <= '0; done <= '0;
                c0_tag <= '0; c0_rd <= '0; c0_value <= '0;
                c1_tag <= '0; c1_rd <= '0; c1_value <= '0;
                store_commit <= 1'b0; flush_out <= 1'b0; flush_pc <= '0;
            end else begin
                c0_tag       <= norm0 ? TAG_W'(head) + TAG_W'(1) : '0;
                c0_rd        <= norm0 ? rd_q[head] : '0;
                c0_value     <= norm0 ? value_q[head] : '0;
                c1_tag       <= norm1 ? TAG_W'(head1) + TAG_W'(1) : '0;
                c1_rd        <= norm1 ? rd_q[head1] : '0;
                c1_value     <= norm1 ? value_q[head1] : '0;
                store_commit <= fire0 && (kind[head] == K_ST);
                flush_out    <= mispredict;
                if (mispredict) flush_pc <= mis0 ? real_pc[head] : real_pc[head1];
                // A mispredict also drops any allocation or writeback landing this edge.
                if (mispredict) begin
                    head <= '0; tail <= '0; count <= '0; done <= '0;
                end else begin
                    head  <= head + IDX_W'(fire0) + IDX_W'(fire1);
                    tail  <= tail + IDX_W'(alloc_fire);
                    count <= count + CNT_W'(alloc_fire) - CNT_W'(fire0) - CNT_W'(fire1);
                    done  <= done_n;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (alloc_fire) begin
                kind[tail]    <= alloc_kind;
                rd_q[tail]    <= alloc_rd;
                pred_pc[tail] <= alloc_pred_pc;
            end
            if (lsb_dest != '0) value_q[lsb_idx] <= lsb_value;
            if (rss_dest != '0) begin
                value_q[rss_idx] <= rss_value;
                real_pc[rss_idx] <= rss_next_pc;
            end
        end
    end
endmodule

// File: tb/tb_rob_queue.sv
// tb/tb_rob_queue.sv - scoreboard bench for rob_queue (DEPTH=16, XLEN=32)
module tb_rob_queue;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst, rdy, flush_in, alloc_valid;
    logic [1:0] alloc_kind;
    logic [4:0] alloc_rd;
    logic [31:0] alloc_pred_pc, lsb_value, rss_value, rss_next_pc;
    logic [TW-1:0] qj, qk, lsb_dest, rss_dest;
    logic full, vj_ok, vk_ok, store_commit, flush_out;
    logic [TW-1:0] alloc_tag, c0_tag, c1_tag;
    logic [4:0] c0_rd, c1_rd;
    logic [31:0] vj, vk, c0_value, c1_value, flush_pc;

    typedef struct packed {
        logic [TW-1:0] t0; logic [4:0] r0; logic [31:0] v0;
        logic [TW-1:0] t1; logic [4:0] r1; logic [31:0] v1;
        logic st; logic fl; logic [31:0] pc;
    } ev_t;

    ev_t sb[$];
    int tests = 0;
    int fails = 0;
    int tail_m;

    rob_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush_in(flush_in), .full(full),
        .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
        .alloc_pred_pc(alloc_pred_pc), .alloc_tag(alloc_tag),
        .qj(qj), .qk(qk), .vj_ok(vj_ok), .vk_ok(vk_ok), .vj(vj), .vk(vk),
        .lsb_dest(lsb_dest), .lsb_value(lsb_value),
        .rss_dest(rss_dest), .rss_value(rss_value), .rss_next_pc(rss_next_pc),
        .c0_tag(c0_tag), .c1_tag(c1_tag), .c0_rd(c0_rd), .c1_rd(c1_rd),
        .c0_value(c0_value), .c1_value(c1_value),
        .store_commit(store_commit), .flush_out(flush_out), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    function automatic ev_t ev(input int t0, input int r0, input int v0,
                               input int t1, input int r1, input int v1,
                               input bit st, input bit fl, input int pc);
        ev_t e;
        e.t0 = TW'(t0); e.r0 = 5'(r0); e.v0 = v0;
        e.t1 = TW'(t1); e.r1 = 5'(r1); e.v1 = v1;
        e.st = st; e.fl = fl; e.pc = pc;
        return e;
    endfunction

    // Monitor: every retire/store/flush event is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (lsb_dest != '0 && rss_dest != '0) begin
                tests++;
                if (lsb_dest == rss_dest) begin
                    fails++;
                    $display("FAIL wb_conflict: both buses target tag %0d, required distinct tags", lsb_dest);
                end
            end
            if (c0_tag != '0 || c1_tag != '0 || store_commit || flush_out) begin
                ev_t act;
                act = {c0_tag, c0_rd, c0_value, c1_tag, c1_rd, c1_value,
                       store_commit, flush_out, flush_out ? flush_pc : 32'h0};
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %h, scoreboard empty", act);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL commit_event: got %h want %h", act, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input int kind, input int rd, input int pc);
        alloc_valid = 1'b1; alloc_kind = 2'(kind); alloc_rd = 5'(rd); alloc_pred_pc = pc;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; flush_in = 1'b0; alloc_valid = 1'b0;
        alloc_kind = '0; alloc_rd = '0; alloc_pred_pc = '0;
        qj = '0; qk = '0; lsb_dest = '0; lsb_value = '0;
        rss_dest = '0; rss_value = '0; rss_next_pc = '0;
        repeat (2) cyc();
        chk("rst_full", full, 0);
        chk("rst_alloc_tag", alloc_tag, 1);
        chk("rst_c0_tag", c0_tag, 0);
        chk("rst_flush_out", flush_out, 0);
        chk("rst_flush_pc", flush_pc, 0);
        rst = 1'b1;

        // Fill all 16 slots, then try a 17th allocation.
        for (int i = 0; i < 16; i++) begin
            alloc(0, 5 + i, 0);
            chk("fill_tag", alloc_tag, i + 1);
            if (i == 15) chk("not_full_before_16", full, 0);
            cyc();
        end
        chk("full_after_16", full, 1);
        chk("tag_when_full", alloc_tag, 1);
        cyc();
        alloc_valid = 1'b0;
        chk("full_held", full, 1);
        chk("tail_unchanged", alloc_tag, 1);

        // Out-of-order writeback, dual commit.
        qj = 5'd2; #1;
        chk("lookup_pending", vj_ok, 0);
        lsb_dest = 5'd2; lsb_value = 32'hB;
        cyc();
        lsb_dest = '0; #1;
        chk("lookup_done_ok", vj_ok, 1);
        chk("lookup_done_v", vj, 32'hB);
        qj = '0;
        lsb_dest = 5'd1; lsb_value = 32'hA;
        sb.push_back(ev(1, 5, 32'hA, 2, 6, 32'hB, 0, 0, 0));
        cyc();
        lsb_dest = '0;
        cyc(); cyc();
        flush_in = 1'b1;
        cyc();
        flush_in = 1'b0;
        chk("flush_in_full", full, 0);
        chk("flush_in_tag", alloc_tag, 1);
        chk("flush_in_flush_out", flush_out, 0);

        // Mispredicted branch at head with done normals behind it.
        alloc(1, 0, 32'h100); cyc();
        alloc(0, 7, 0);       cyc();
        alloc(0, 8, 0);       cyc();
        alloc_valid = 1'b0;
        lsb_dest = 5'd2; lsb_value = 32'h22; cyc();
        lsb_dest = 5'd3; lsb_value = 32'h33; cyc();
        lsb_dest = '0;
        rss_dest = 5'd1; rss_value = 32'h0; rss_next_pc = 32'h200;
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1, 32'h200));
        cyc();
        rss_dest = '0;
        cyc();
        chk("flush_cycle_tag", alloc_tag, 1);
        chk("flush_cycle_full", full, 0);
        alloc(0, 9, 0); cyc();
        alloc_valid = 1'b0;
        lsb_dest = 5'd1; lsb_value = 32'h99;
        sb.push_back(ev(1, 9, 32'h99, 0, 0, 0, 0, 0, 0));
        cyc();
        lsb_dest = '0;

        // Store at head with a done normal behind it.
        alloc(2, 0, 0);
        chk("store_tag", alloc_tag, 2);
        cyc();
        alloc(0, 10, 0);
        chk("normal_after_store_tag", alloc_tag, 3);
        cyc();
        alloc_valid = 1'b0;
        lsb_dest = 5'd3; lsb_value = 32'h77; cyc();
        lsb_dest = 5'd2; lsb_value = 32'h0;
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 1, 0, 0));
        sb.push_back(ev(3, 10, 32'h77, 0, 0, 0, 0, 0, 0));
        cyc();
        lsb_dest = '0;
        cyc(); cyc();
        flush_in = 1'b1; cyc(); flush_in = 1'b0;

        // Same-cycle lookup against the RSS bus.
        alloc(0, 1, 0); cyc();
        alloc(0, 2, 0); cyc();
        alloc(0, 3, 0); cyc();
        alloc_valid = 1'b0;
        rss_dest = 5'd3; rss_value = 32'h55; rss_next_pc = 32'h0; qj = 5'd3; #1;
`ifdef ROB_BYPASS_EN
        chk("bypass_ok", vj_ok, 1);
        chk("bypass_v", vj, 32'h55);
`else
        chk("nobypass_ok", vj_ok, 0);
        chk("nobypass_v", vj, 0);
`endif
        cyc();
        rss_dest = '0; #1;
        chk("stored_ok", vj_ok, 1);
        chk("stored_v", vj, 32'h55);
        qk = 5'd2; qj = '0; #1;
        chk("pending_k_ok", vk_ok, 0);
        chk("pending_k_v", vk, 0);
        chk("none_j_ok", vj_ok, 0);
        qk = '0;
        lsb_dest = 5'd1; lsb_value = 32'h11;
        rss_dest = 5'd2; rss_value = 32'h12;
        sb.push_back(ev(1, 1, 32'h11, 2, 2, 32'h12, 0, 0, 0));
        sb.push_back(ev(3, 3, 32'h55, 0, 0, 0, 0, 0, 0));
        cyc();
        lsb_dest = '0; rss_dest = '0;
        cyc(); cyc();

        // Wraparound: one allocate/writeback/commit stream, occupancy stays at one.
        tail_m = 3;
        for (int k = 0; k < 40; k++) begin
            alloc(0, k % 32, 0);
            chk("wrap_tag", alloc_tag, tail_m + 1);
            cyc();
            alloc_valid = 1'b0;
            lsb_dest = TW'(tail_m + 1); lsb_value = 32'h1000 + k;
            sb.push_back(ev(tail_m + 1, k % 32, 32'h1000 + k, 0, 0, 0, 0, 0, 0));
            cyc();
            lsb_dest = '0;
            tail_m = (tail_m + 1) % 16;
        end
        chk("wrap_not_full", full, 0);

        // Asynchronous reset mid-operation.
        alloc(0, 4, 0); cyc();
        alloc(0, 4, 0); cyc();
        alloc_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tag", alloc_tag, 1);
        chk("async_rst_full", full, 0);
        cyc();
        rst = 1'b1;
        alloc(0, 20, 0);
        chk("post_rst_tag", alloc_tag, 1);
        cyc();
        alloc_valid = 1'b0;
        lsb_dest = 5'd1; lsb_value = 32'hAB;
        sb.push_back(ev(1, 20, 32'hAB, 0, 0, 0, 0, 0, 0));
        cyc();
        lsb_dest = '0;
        repeat (4) cyc();
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
